// File: rtl/sprite_pkg.sv
// Shared constants, types and helpers for the sprite motion controller.
// Screen geometry, descriptor field layout and pad bit positions live here.
package sprite_pkg;

  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    RISING   = 2'd1,
    FALLING  = 2'd2,
    INVALID  = 2'd3
  } motionState_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SPRITE_W = 256;
  localparam int SPRITE_H = 125;

  // Largest legal bottom-left corner that keeps the whole sprite on screen
  localparam int X_MAX = SCREEN_W - SPRITE_W;
  localparam int Y_MAX = SCREEN_H - SPRITE_H;

  localparam int SD_X_LSB = 48;
  localparam int SD_Y_LSB = 32;
  localparam int SD_W_LSB = 16;
  localparam int SD_H_LSB = 0;

  localparam int PAD_RIGHT = 26;
  localparam int PAD_LEFT  = 27;
  localparam int PAD_JUMP  = 28;

  function automatic logic [63:0] packSprite(input logic [15:0] x, input logic [15:0] y);
    logic [63:0] d;
    d = '0;
    d[SD_X_LSB +: 16] = x;
    d[SD_Y_LSB +: 16] = y;
    d[SD_W_LSB +: 16] = 16'(SPRITE_W);
    d[SD_H_LSB +: 16] = 16'(SPRITE_H);
    return d;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bank for asynchronous pad inputs.
// Each bit gets its own independent flop pair.
module sync2 #(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] asyncIn,
  output logic [WIDTH-1:0] syncOut
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic stage1Reg;
    logic stage2Reg;

    always_ff @(posedge clock) begin
      if (reset) begin
        stage1Reg <= 1'b0;
        stage2Reg <= 1'b0;
      end else begin
        stage1Reg <= asyncIn[gi];
        stage2Reg <= stage1Reg;
      end
    end

    assign syncOut[gi] = stage2Reg;
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite position/jump controller: walks, jumps under gravity,
// clamps to screen edges and publishes one descriptor per video frame.
module sprite_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int X_INIT     = 64,
  parameter int GROUND_Y   = 40,
  parameter int WALK_SPEED = 4,
  parameter int JUMP_VEL   = 12,
  parameter int GRAVITY    = 1,
  parameter int MAX_FALL   = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [31:0] controller,
  output logic [63:0] sprite_data,
  output logic        facing_right,
  output logic [1:0]  motion_state,
  output logic        update_pulse
);

  localparam logic [15:0]        X_LIMIT   = 16'(X_MAX);
  localparam logic [15:0]        WALK_STEP = 16'(WALK_SPEED);
  localparam logic [15:0]        X_START   = 16'(X_INIT);
  localparam logic signed [11:0] Y_GROUND  = 12'(GROUND_Y);
  localparam logic signed [11:0] Y_CEIL    = 12'(Y_MAX);
  localparam logic signed [11:0] Y_JUMP    = 12'(JUMP_VEL);
  localparam logic signed [7:0]  VY_JUMP   = 8'(JUMP_VEL);
  localparam logic signed [7:0]  VY_GRAV   = 8'(GRAVITY);
  localparam logic signed [7:0]  VY_FLOOR  = 8'(-MAX_FALL);

  logic [2:0] padSync;
  logic       rightBtn;
  logic       leftBtn;
  logic       jumpBtn;
  logic       unusedPadBits;

  sync2 #(.WIDTH(3)) u_sync2 (
    .clock   (clock),
    .reset   (reset),
    .asyncIn ({controller[PAD_JUMP], controller[PAD_LEFT], controller[PAD_RIGHT]}),
    .syncOut (padSync)
  );

  assign rightBtn      = padSync[0];
  assign leftBtn       = padSync[1];
  assign jumpBtn       = padSync[2];
  assign unusedPadBits = ^{controller[31:29], controller[25:0]};

  logic [15:0]        xReg,      xNext;
  logic signed [11:0] yReg,      yNext;
  logic signed [7:0]  vyReg,     vyNext;
  logic               facingReg, facingNext;
  motionState_t       stateReg,  stateNext;
  logic               pulseReg;

  logic signed [11:0] airY;
  logic signed [7:0]  vyDec;
  logic signed [7:0]  vyClamped;

  always_comb begin
    xNext      = xReg;
    facingNext = facingReg;
    yNext      = yReg;
    vyNext     = vyReg;
    stateNext  = stateReg;

    airY      = yReg + {{4{vyReg[7]}}, vyReg};
    vyDec     = vyReg - VY_GRAV;
    vyClamped = (vyDec < VY_FLOOR) ? VY_FLOOR : vyDec;

    // Pressing both directions cancels out, leaving position and facing alone
    if (rightBtn && !leftBtn) begin
      facingNext = 1'b1;
      xNext      = (xReg > X_LIMIT - WALK_STEP) ? X_LIMIT : xReg + WALK_STEP;
    end else if (leftBtn && !rightBtn) begin
      facingNext = 1'b0;
      xNext      = (xReg < WALK_STEP) ? 16'd0 : xReg - WALK_STEP;
    end

    case (stateReg)
      GROUNDED: begin
        if (jumpBtn) begin
          yNext     = yReg + Y_JUMP;
          vyNext    = VY_JUMP - VY_GRAV;
          stateNext = RISING;
        end
      end
      RISING, FALLING: begin
        if (airY <= Y_GROUND) begin
          yNext     = Y_GROUND;
          vyNext    = '0;
          stateNext = GROUNDED;
        end else if (airY > Y_CEIL) begin
          yNext     = Y_CEIL;
          vyNext    = '0;
          stateNext = FALLING;
        end else begin
          yNext     = airY;
          vyNext    = vyClamped;
          stateNext = (vyClamped > 8'sd0) ? RISING : FALLING;
        end
      end
      default: stateNext = FALLING;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      xReg      <= X_START;
      yReg      <= Y_GROUND;
      vyReg     <= '0;
      facingReg <= 1'b1;
      stateReg  <= GROUNDED;
      pulseReg  <= 1'b0;
    end else begin
      pulseReg <= frame_tick;
      if (frame_tick) begin
        xReg      <= xNext;
        yReg      <= yNext;
        vyReg     <= vyNext;
        facingReg <= facingNext;
        stateReg  <= stateNext;
      end
    end
  end

  assign sprite_data  = packSprite(xReg, {4'b0000, yReg});
  assign facing_right = facingReg;
  assign motion_state = stateReg;
  assign update_pulse = pulseReg;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: stimulus pushes expected frames
// from a plain-arithmetic model, a monitor pops and compares on update_pulse.
module tb_sprite_motion_ctrl;

  localparam logic [31:0] P_RIGHT = 32'h0400_0000;
  localparam logic [31:0] P_LEFT  = 32'h0800_0000;
  localparam logic [31:0] P_JUMP  = 32'h1000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic [31:0] controller = '0;
  logic [63:0] sprite_data;
  logic        facing_right;
  logic [1:0]  motion_state;
  logic        update_pulse;

  sprite_motion_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .controller   (controller),
    .sprite_data  (sprite_data),
    .facing_right (facing_right),
    .motion_state (motion_state),
    .update_pulse (update_pulse)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] data;
    logic        facing;
    logic [1:0]  state;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state, in plain integers
  int mx, my, mvy, ms;
  bit mf;

  function automatic logic [63:0] packExp(int x, int y);
    logic [15:0] x16, y16;
    x16 = 16'(x);
    y16 = 16'(y);
    return {x16, y16, 16'd256, 16'd125};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mx = 64; my = 40; mvy = 0; ms = 0; mf = 1'b1;
  endtask

  task automatic modelStep(logic [31:0] pad);
    bit r, l, j;
    int ny, nvy;
    r = pad[26]; l = pad[27]; j = pad[28];
    if (r && !l) begin
      mx = (mx + 4 > 384) ? 384 : mx + 4;
      mf = 1'b1;
    end else if (l && !r) begin
      mx = (mx - 4 < 0) ? 0 : mx - 4;
      mf = 1'b0;
    end
    if (ms == 0) begin
      if (j) begin
        my = my + 12; mvy = 11; ms = 1;
      end
    end else begin
      ny  = my + mvy;
      nvy = (mvy - 1 < -12) ? -12 : mvy - 1;
      if (ny <= 40) begin
        my = 40; mvy = 0; ms = 0;
      end else if (ny > 355) begin
        my = 355; mvy = 0; ms = 2;
      end else begin
        my = ny; mvy = nvy; ms = (nvy > 0) ? 1 : 2;
      end
    end
  endtask

  task automatic frame(logic [31:0] pad, bit glitchEn, logic [31:0] glitchVal);
    exp_t e;
    @(negedge clock);
    controller = pad;
    repeat (3) @(negedge clock);
    frame_tick = 1'b1;
    modelStep(pad);
    e.data = packExp(mx, my); e.facing = mf; e.state = 2'(ms);
    expQ.push_back(e);
    @(negedge clock);
    frame_tick = 1'b0;
    if (glitchEn) begin
      controller = glitchVal;
      @(negedge clock);
      controller = pad;
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic doReset(bit withTick, logic [31:0] pad);
    @(negedge clock);
    reset = 1'b1;
    frame_tick = withTick;
    controller = pad;
    repeat (2) @(negedge clock);
    frame_tick = 1'b0;
    reset = 1'b0;
    controller = '0;
    modelReset();
  endtask

  // Monitor: samples inputs at the edge, outputs 1 time unit later
  logic [63:0] lastData;
  logic        lastFacing;
  logic [1:0]  lastState;
  logic        rstSeen, tickSeen;

  always @(posedge clock) begin
    rstSeen  = reset;
    tickSeen = frame_tick && !reset;
    #1;
    if (rstSeen) begin
      lastData = packExp(64, 40); lastFacing = 1'b1; lastState = 2'd0;
      check("reset_data",   sprite_data,  lastData);
      check("reset_facing", 64'(facing_right), 64'(lastFacing));
      check("reset_state",  64'(motion_state), 64'(lastState));
      check("reset_pulse",  64'(update_pulse), 64'd0);
    end else begin
      check("pulse_timing", 64'(update_pulse), 64'(tickSeen));
      if (update_pulse) begin
        if (expQ.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_update: got pulse expected none at %0t", $time);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          check("frame_data",   sprite_data, e.data);
          check("frame_facing", 64'(facing_right), 64'(e.facing));
          check("frame_state",  64'(motion_state), 64'(e.state));
          $display("frame x=%0d y=%0d facing=%0d state=%0d", sprite_data[63:48], sprite_data[47:32], facing_right, motion_state);
          lastData = e.data; lastFacing = e.facing; lastState = e.state;
        end
      end else begin
        check("hold_data",   sprite_data, lastData);
        check("hold_facing", 64'(facing_right), 64'(lastFacing));
        check("hold_state",  64'(motion_state), 64'(lastState));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    modelReset();
    // Reset with a coincident frame tick and right held: tick must be discarded
    doReset(1'b1, P_RIGHT);
    repeat (3) @(negedge clock);

    for (int i = 0; i < 3; i++) frame(P_RIGHT, 1'b0, '0);
    for (int i = 0; i < 18; i++) frame(P_LEFT, 1'b0, '0);
    for (int i = 0; i < 2; i++) frame(P_LEFT, 1'b0, '0);
    frame(P_LEFT | P_RIGHT, 1'b0, '0);
    frame(P_LEFT | P_RIGHT | 32'h0000_00FF, 1'b0, '0);

    // One-cycle glitches between ticks must not move the sprite
    frame(32'h0, 1'b1, P_RIGHT | P_JUMP);
    frame(32'h0, 1'b1, P_LEFT | P_JUMP);
    frame(32'h0, 1'b0, '0);

    // Full jump with jump held throughout the flight
    frame(P_JUMP, 1'b0, '0);
    guard = 0;
    while (ms != 0 && guard < 80) begin
      frame(P_JUMP, 1'b0, '0);
      guard++;
    end
    frame(32'h0, 1'b0, '0);

    // Abort a jump with reset at y=90 while rising
    frame(P_JUMP, 1'b0, '0);
    for (int i = 0; i < 4; i++) frame(32'h0, 1'b0, '0);
    doReset(1'b0, 32'h0);
    frame(32'h0, 1'b0, '0);
    frame(32'h0, 1'b0, '0);

    // Right wall
    for (int i = 0; i < 82; i++) frame(P_RIGHT, 1'b0, '0);
    frame(P_RIGHT | P_JUMP, 1'b0, '0);

    // Randomized frames with random glitches
    for (int i = 0; i < 150; i++) begin
      logic [31:0] pad, gl;
      pad = $urandom;
      gl  = $urandom;
      frame(pad, 1'($urandom_range(0, 1)), gl);
    end

    repeat (5) @(negedge clock);
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
